// File: rtl/reloj_pkg.sv
// Shared clock-domain definitions: FSM encoding, field indices and BCD limits
// used by the time editor and its per-field counters.
package reloj_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EDIT   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam int F_SEG = 0;
  localparam int F_MIN = 1;
  localparam int F_HOR = 2;
  localparam int N_FIELDS = 3;

  localparam logic [7:0] MAX_HOR_DEF = 8'h23;
  localparam logic [7:0] MAX_MIN_DEF = 8'h59;

  // Two-digit decimal to packed BCD, used to turn the decimal limits into bytes.
  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'((v / 10) % 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/ajuste_hora_bcd_updown.sv
// One BCD time field: loadable register that counts up/down with wrap-around
// between 00 and MAX, clamping invalid loads to 00.
module bcd_updown
  import reloj_pkg::*;
#(
  parameter logic [7:0] MAX = MAX_MIN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] q
);

  logic [7:0] q_reg;
  logic [7:0] inc_next;
  logic [7:0] dec_next;
  logic       din_ok;

  // Valid BCD bytes order the same way as their decimal values, so a plain
  // byte compare against MAX is a correct range check.
  always_comb begin
    din_ok = (din[3:0] <= 4'd9) && (din[7:4] <= 4'd9) && (din <= MAX);

    inc_next = q_reg + 8'd1;
    if (q_reg == MAX)
      inc_next = 8'h00;
    else if (q_reg[3:0] == 4'd9)
      inc_next = {q_reg[7:4] + 4'd1, 4'd0};

    dec_next = q_reg - 8'd1;
    if (q_reg == 8'h00)
      dec_next = MAX;
    else if (q_reg[3:0] == 4'd0)
      dec_next = {q_reg[7:4] - 4'd1, 4'd9};
  end

  always_ff @(posedge clk) begin
    if (reset)
      q_reg <= 8'h00;
    else if (load)
      q_reg <= din_ok ? din : 8'h00;
    else if (inc && !dec)
      q_reg <= inc_next;
    else if (dec && !inc)
      q_reg <= dec_next;
  end

  assign q = q_reg;

endmodule

// File: rtl/ajuste_hora.sv
// Time-field editor: captures the running time on edit entry, steps the
// selected BCD field from button pulses and strobes a commit on exit.
module ajuste_hora
  import reloj_pkg::*;
#(
  parameter int HOUR_MAX = 23,
  parameter int MIN_MAX  = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       edit,
  input  logic       up,
  input  logic       down,
  input  logic       sel,
  input  logic [7:0] hh_in,
  input  logic [7:0] mm_in,
  input  logic [7:0] ss_in,
  output logic [7:0] hh_out,
  output logic [7:0] mm_out,
  output logic [7:0] ss_out,
  output logic [1:0] cursor,
  output logic       editing,
  output logic       wr_stb
);

  localparam logic [7:0] HOR_BCD = to_bcd(HOUR_MAX);
  localparam logic [7:0] MIN_BCD = to_bcd(MIN_MAX);

  logic [1:0] state_reg;
  logic [1:0] cursor_reg;
  logic       load;
  logic       active;
  logic [N_FIELDS-1:0] inc_f;
  logic [N_FIELDS-1:0] dec_f;
  logic [7:0] din_f [N_FIELDS];
  logic [7:0] q_f   [N_FIELDS];

  // Pulses only count in EDIT while edit is still held; the exit cycle drops them.
  assign load   = (state_reg == ST_IDLE) && edit;
  assign active = (state_reg == ST_EDIT) && edit;

  assign din_f[F_SEG] = ss_in;
  assign din_f[F_MIN] = mm_in;
  assign din_f[F_HOR] = hh_in;

  genvar gi;
  generate
    for (gi = 0; gi < N_FIELDS; gi++) begin : g_field
      localparam logic [7:0] FMAX = (gi == F_HOR) ? HOR_BCD : MIN_BCD;

      assign inc_f[gi] = active && up   && (cursor_reg == 2'(gi));
      assign dec_f[gi] = active && down && (cursor_reg == 2'(gi));

      bcd_updown #(.MAX(FMAX)) u_field (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .din   (din_f[gi]),
        .inc   (inc_f[gi]),
        .dec   (dec_f[gi]),
        .q     (q_f[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      cursor_reg <= 2'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (edit) begin
            state_reg  <= ST_EDIT;
            cursor_reg <= 2'd0;
          end
        end
        ST_EDIT: begin
          if (!edit)
            state_reg <= ST_COMMIT;
          else if (sel)
            cursor_reg <= (cursor_reg == 2'd2) ? 2'd0 : cursor_reg + 2'd1;
        end
        ST_COMMIT: state_reg <= ST_IDLE;
        default:   state_reg <= ST_IDLE;
      endcase
    end
  end

  assign hh_out  = q_f[F_HOR];
  assign mm_out  = q_f[F_MIN];
  assign ss_out  = q_f[F_SEG];
  assign cursor  = cursor_reg;
  assign editing = (state_reg == ST_EDIT);
  assign wr_stb  = (state_reg == ST_COMMIT);

endmodule

// File: tb/tb_ajuste_hora.sv
// Bench for ajuste_hora: directed vector table followed by random pulses
// checked against an integer-arithmetic model of the editor.
module tb_ajuste_hora;

  logic       clk = 1'b0;
  logic       reset, edit, up, down, sel;
  logic [7:0] hh_in, mm_in, ss_in;
  logic [7:0] hh_out, mm_out, ss_out;
  logic [1:0] cursor;
  logic       editing, wr_stb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ajuste_hora dut (
    .clk     (clk),
    .reset   (reset),
    .edit    (edit),
    .up      (up),
    .down    (down),
    .sel     (sel),
    .hh_in   (hh_in),
    .mm_in   (mm_in),
    .ss_in   (ss_in),
    .hh_out  (hh_out),
    .mm_out  (mm_out),
    .ss_out  (ss_out),
    .cursor  (cursor),
    .editing (editing),
    .wr_stb  (wr_stb)
  );

  typedef struct {
    logic       rst, ed, u, d, s;
    logic [7:0] hi, mi, si;
    logic [7:0] eh, em, es;
    logic [1:0] ec;
    logic       eed, ewr;
  } vec_t;

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  // Decimal value of a captured byte, or 0 if it is not a legal value for the field.
  function automatic int capture(input logic [7:0] b, input int maxv);
    int v;
    if (b[3:0] > 4'd9 || b[7:4] > 4'd9) return 0;
    v = int'(b[7:4]) * 10 + int'(b[3:0]);
    return (v > maxv) ? 0 : v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, e, u, d, s, input logic [7:0] hi, mi, si);
    reset = r; edit = e; up = u; down = d; sel = s;
    hh_in = hi; mm_in = mi; ss_in = si;
    @(posedge clk);
    #1;
  endtask

  // Reference model: fields as plain decimal integers, mode 0/1/2 = idle/edit/commit.
  int m_f[3];
  int m_cur, m_mode;
  int m_max[3] = '{59, 59, 23};

  task automatic model_step(input logic r, e, u, d, s, input logic [7:0] hi, mi, si);
    if (r) begin
      m_f = '{0, 0, 0}; m_cur = 0; m_mode = 0;
    end else if (m_mode == 0) begin
      if (e) begin
        m_f[0] = capture(si, 59);
        m_f[1] = capture(mi, 59);
        m_f[2] = capture(hi, 23);
        m_cur = 0; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (!e) m_mode = 2;
      else begin
        if (u && !d) m_f[m_cur] = (m_f[m_cur] + 1) % (m_max[m_cur] + 1);
        if (d && !u) m_f[m_cur] = (m_f[m_cur] + m_max[m_cur]) % (m_max[m_cur] + 1);
        if (s) m_cur = (m_cur + 1) % 3;
      end
    end else begin
      m_mode = 0;
    end
  endtask

  vec_t vecs[$];

  initial begin
    //            rst ed  u  d  s  hh_in  mm_in  ss_in   hh     mm     ss   cur ed wr
    vecs.push_back('{1, 0, 0, 0, 0, 8'h12, 8'h34, 8'h59, 8'h00, 8'h00, 8'h00, 0, 0, 0});
    vecs.push_back('{0, 1, 1, 0, 1, 8'h12, 8'h34, 8'h59, 8'h12, 8'h34, 8'h59, 0, 1, 0});
    vecs.push_back('{0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h00, 0, 1, 0});
    vecs.push_back('{0, 1, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h00, 0, 1, 0});
    vecs.push_back('{0, 1, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h00, 1, 1, 0});
    vecs.push_back('{0, 1, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h00, 2, 1, 0});
    vecs.push_back('{0, 1, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h11, 8'h34, 8'h00, 2, 1, 0});
    vecs.push_back('{0, 1, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h11, 8'h34, 8'h00, 0, 1, 0});
    vecs.push_back('{0, 1, 1, 0, 1, 8'h00, 8'h00, 8'h00, 8'h11, 8'h34, 8'h01, 1, 1, 0});
    vecs.push_back('{0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h11, 8'h34, 8'h01, 1, 0, 1});
    vecs.push_back('{0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h11, 8'h34, 8'h01, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 1, 8'h00, 8'h00, 8'h00, 8'h11, 8'h34, 8'h01, 1, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h09, 8'h00, 8'h00, 8'h09, 0, 1, 0});
    vecs.push_back('{0, 1, 1, 0, 1, 8'h00, 8'h00, 8'h09, 8'h00, 8'h00, 8'h10, 1, 1, 0});
    vecs.push_back('{0, 1, 0, 1, 0, 8'h00, 8'h00, 8'h09, 8'h00, 8'h59, 8'h10, 1, 1, 0});
    vecs.push_back('{0, 1, 0, 0, 1, 8'h00, 8'h00, 8'h09, 8'h00, 8'h59, 8'h10, 2, 1, 0});
    vecs.push_back('{0, 1, 0, 1, 0, 8'h00, 8'h00, 8'h09, 8'h23, 8'h59, 8'h10, 2, 1, 0});
    vecs.push_back('{0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h09, 8'h00, 8'h59, 8'h10, 2, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h09, 8'h00, 8'h59, 8'h10, 2, 0, 1});
    vecs.push_back('{0, 1, 0, 0, 0, 8'h25, 8'h34, 8'h7A, 8'h00, 8'h59, 8'h10, 2, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 0, 8'h25, 8'h34, 8'h7A, 8'h00, 8'h34, 8'h00, 0, 1, 0});
    vecs.push_back('{0, 1, 1, 0, 0, 8'h25, 8'h34, 8'h7A, 8'h00, 8'h34, 8'h01, 0, 1, 0});
    vecs.push_back('{1, 1, 0, 0, 0, 8'h25, 8'h34, 8'h7A, 8'h00, 8'h00, 8'h00, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 0, 1, 8'h25, 8'h34, 8'h7A, 8'h00, 8'h00, 8'h00, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 8'h25, 8'h34, 8'h7A, 8'h00, 8'h00, 8'h00, 0, 0, 0});

    reset = 1'b1; edit = 1'b0; up = 1'b0; down = 1'b0; sel = 1'b0;
    hh_in = 8'h00; mm_in = 8'h00; ss_in = 8'h00;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ed, vecs[i].u, vecs[i].d, vecs[i].s,
            vecs[i].hi, vecs[i].mi, vecs[i].si);
      $display("vec %0d: hh=%h mm=%h ss=%h cursor=%0d editing=%b wr_stb=%b",
               i, hh_out, mm_out, ss_out, cursor, editing, wr_stb);
      check($sformatf("vec%0d hh_out", i), hh_out, vecs[i].eh);
      check($sformatf("vec%0d mm_out", i), mm_out, vecs[i].em);
      check($sformatf("vec%0d ss_out", i), ss_out, vecs[i].es);
      check($sformatf("vec%0d cursor", i), 8'(cursor), 8'(vecs[i].ec));
      check($sformatf("vec%0d editing", i), 8'(editing), 8'(vecs[i].eed));
      check($sformatf("vec%0d wr_stb", i), 8'(wr_stb), 8'(vecs[i].ewr));
    end

    // Random phase starts from a clean reset of both DUT and model.
    drive(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    model_step(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);

    begin
      logic r, e, u, d, s;
      logic [7:0] hi, mi, si;
      e = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        r = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 9) == 0) e = ~e;
        u = ($urandom_range(0, 2) == 0);
        d = ($urandom_range(0, 2) == 0);
        s = ($urandom_range(0, 3) == 0);
        hi = ($urandom_range(0, 7) == 0) ? 8'($urandom) : bcd($urandom_range(0, 23));
        mi = ($urandom_range(0, 7) == 0) ? 8'($urandom) : bcd($urandom_range(0, 59));
        si = ($urandom_range(0, 7) == 0) ? 8'($urandom) : bcd($urandom_range(0, 59));
        drive(r, e, u, d, s, hi, mi, si);
        model_step(r, e, u, d, s, hi, mi, si);
        if (n % 100 == 0)
          $display("rnd %0d: hh=%h mm=%h ss=%h cursor=%0d editing=%b wr_stb=%b",
                   n, hh_out, mm_out, ss_out, cursor, editing, wr_stb);
        check("rnd hh_out", hh_out, bcd(m_f[2]));
        check("rnd mm_out", mm_out, bcd(m_f[1]));
        check("rnd ss_out", ss_out, bcd(m_f[0]));
        check("rnd cursor", 8'(cursor), 8'(m_cur));
        check("rnd editing", 8'(editing), 8'(m_mode == 1));
        check("rnd wr_stb", 8'(wr_stb), 8'(m_mode == 2));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ajuste_hora.md
# ajuste_hora

Time-field editor that turns debounced, single-cycle button pulses into edits of a BCD hours/minutes/seconds value. It sits directly downstream of the button pulse stages (debounce plus rising-edge one-shot, one per button) and upstream of the RTC write path. While `edit` is high it captures the current time, lets the user select a field and step it up or down with wrap-around, then issues a one-cycle commit strobe when `edit` drops.

## Interface
Parameters:
- `HOUR_MAX`, default 23: maximum hours value, treated as a decimal number and held in BCD.
- `MIN_MAX`, default 59: maximum value for minutes and for seconds.

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `edit`  in  1  level; high means edit mode is requested.
- `up`  in  1  single-cycle pulse; increment the selected field.
- `down`  in  1  single-cycle pulse; decrement the selected field.
- `sel`  in  1  single-cycle pulse; advance the cursor.
- `hh_in`, `mm_in`, `ss_in`  in  8 each  BCD time, captured on entry to edit mode.
- `hh_out`, `mm_out`, `ss_out`  out  8 each  edited BCD time, registered.
- `cursor`  out  2  selected field: 0 = seconds, 1 = minutes, 2 = hours. The value 3 never occurs.
- `editing`  out  1  high while the FSM is in the EDIT state.
- `wr_stb`  out  1  one-cycle commit pulse.

## Operation
- **Reset:** state is IDLE. All outputs are 0: `hh_out`, `mm_out`, `ss_out` = 8'h00, `cursor` = 0, `editing` = 0, `wr_stb` = 0.
- **FSM states:** IDLE, EDIT, COMMIT.
- **IDLE:**
  - `edit` = 1 → capture `hh_in`, `mm_in`, `ss_in` into the output registers, set `cursor` = 0, go to EDIT.
  - `up`, `down` and `sel` are ignored.
  - Output registers hold their last values.
- **EDIT:**
  - `edit` = 0 → go to COMMIT. Any pulse in the same cycle is ignored.
  - `up` alone → selected field +1. At its max the field wraps to 00.
  - `down` alone → selected field −1. At 00 the field wraps to its max.
  - `up` and `down` together → no change.
  - `sel` → `cursor` advances 0→1→2→0.
  - `sel` together with `up` or `down` → the step applies to the old cursor's field, and the cursor advances in the same edge.
- **COMMIT:** `wr_stb` = 1 for exactly one cycle, then go to IDLE.
  - If `edit` is high again during COMMIT, the FSM still goes to IDLE. The re-capture happens on the following edge.
- **BCD arithmetic:** per nibble.
  - Ones digit 9 + 1 → 0 with a carry into tens.
  - Ones digit 0 − 1 → 9 with a borrow from tens.
  - The wrap comparison is against the whole BCD byte of `HOUR_MAX` / `MIN_MAX`.
- **Invalid capture:** a nibble > 9, or a value above the field max, is loaded as 8'h00.
- **Reset mid-edit:** returns to IDLE with outputs zeroed. No `wr_stb` is issued.

## Timing
- Entry capture: the edge that first samples `edit` = 1 loads the registers. `editing` = 1 from that edge.
- A pulse arriving in the same cycle as the `edit` rise is ignored. The first pulse accepted is one sampled at the next edge.
- Field or cursor change is visible one cycle after the pulse is sampled.
- Exit sequence after the edge that samples `edit` = 0:
  - `editing` = 0.
  - `wr_stb` = 1 for one cycle.
  - Outputs are stable throughout `wr_stb` and afterwards.
- Minimum spacing between accepted pulses: 1 cycle. Back-to-back pulses each take effect.

## Structure
- Shared package `reloj_pkg` holds:
  - state encoding (IDLE, EDIT, COMMIT);
  - field indices `F_SEG` = 0, `F_MIN` = 1, `F_HOR` = 2;
  - default max constants 8'h23 and 8'h59.
- One sub-module, `bcd_updown`. It is a single BCD field register with:
  - parameter MAX;
  - inputs load, din, inc, dec;
  - output q;
  - invalid-load clamping.
- `bcd_updown` is instantiated three times. The FSM, cursor and decode of the per-field inc/dec enables live in `ajuste_hora`.

## Test plan
- Reset, then `hh_in`/`mm_in`/`ss_in` = 12/34/56 and `edit` = 1 → next edge: outputs 12/34/56, `cursor` = 0, `editing` = 1.
- Field 0 at 59, one `up` pulse → `ss_out` = 00 and `mm_out` unchanged. Then `sel`, `sel`, `down` with hours at 00 → `hh_out` = 23.
- `up` and `down` together → no change. `sel` and `up` together with `cursor` = 0 and ss = 09 → ss = 10 and `cursor` = 1 after one edge.
- `edit` dropped in the same cycle as `up` → no field change. `wr_stb` is high exactly one cycle and the values are unchanged.
- Capture of `ss_in` = 8'h7A or `hh_in` = 8'h25 → that field loads 8'h00.
- `reset` asserted while in EDIT → all outputs 0, no `wr_stb`. Pulses while IDLE change nothing.
